// File: rtl/roulette_spinner.sv
// roulette_spinner: number source for the roulette game.
// A falling edge on the spin key starts a timed wheel spin with an animated
// display, after which a pseudo-random result in 1..RANGE_MAX is presented
// together with a one-cycle result_valid pulse.

module roulette_spinner #(
  parameter int         RANGE_MAX   = 31,
  parameter int         SPIN_CYCLES = 25_000_000,
  parameter int         STEP_DIV    = 2_500_000,
  parameter logic [4:0] SEED        = 5'b10101
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       spin_n,
  input  logic       seed_load,
  input  logic [4:0] seed,
  output logic       busy,
  output logic [4:0] display,
  output logic [4:0] result,
  output logic       result_odd,
  output logic       result_valid
);

  // Counter widths; a single bit is kept when the terminal count is 0.
  localparam int SPIN_CNT_W = (SPIN_CYCLES > 1) ? $clog2(SPIN_CYCLES) : 1;
  localparam int STEP_CNT_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  localparam logic [SPIN_CNT_W-1:0] SPIN_LAST = SPIN_CNT_W'(SPIN_CYCLES - 1);
  localparam logic [STEP_CNT_W-1:0] STEP_LAST = STEP_CNT_W'(STEP_DIV - 1);
  localparam logic [4:0]            RANGE_HI  = 5'(RANGE_MAX);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SPIN   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Synchroniser and edge detector. All stages reset to the released key
  // level so that leaving reset never fabricates a press.
  logic spin_meta_q;
  logic spin_sync_q;
  logic spin_prev_q;
  logic spin_evt;

  // FSM and datapath state.
  state_t                state_q,    state_d;
  logic [4:0]            lfsr_q,     lfsr_d;
  logic [SPIN_CNT_W-1:0] spin_cnt_q, spin_cnt_d;
  logic [STEP_CNT_W-1:0] step_cnt_q, step_cnt_d;
  logic [4:0]            display_q,  display_d;
  logic [4:0]            result_q,   result_d;
  logic                  odd_q,      odd_d;
  logic                  lfsr_in_range;

  // Bring the asynchronous key into the clock domain and keep its last level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      spin_meta_q <= 1'b1;
      spin_sync_q <= 1'b1;
      spin_prev_q <= 1'b1;
    end else begin
      spin_meta_q <= spin_n;
      spin_sync_q <= spin_meta_q;
      spin_prev_q <= spin_sync_q;
    end
  end

  // A press is the high-to-low transition of the synchronised key.
  assign spin_evt = spin_prev_q & ~spin_sync_q;

  // A usable result is any nonzero LFSR value not above RANGE_MAX.
  assign lfsr_in_range = (lfsr_q != 5'd0) && (lfsr_q <= RANGE_HI);

  // LFSR next value: free-running x^5+x^3+1 shift, seed load only when idle
  // and not starting a spin in the same cycle; a zero seed would lock up.
  always_comb begin
    lfsr_d = {lfsr_q[3:0], lfsr_q[4] ^ lfsr_q[2]};
    if ((state_q == ST_IDLE) && seed_load && !spin_evt) begin
      lfsr_d = (seed == 5'd0) ? 5'd1 : seed;
    end
  end

  // Next-state and datapath logic for the spin sequence.
  always_comb begin
    state_d    = state_q;
    spin_cnt_d = spin_cnt_q;
    step_cnt_d = step_cnt_q;
    display_d  = display_q;
    result_d   = result_q;
    odd_d      = odd_q;

    unique case (state_q)
      ST_IDLE: begin
        if (spin_evt) begin
          state_d    = ST_SPIN;
          spin_cnt_d = '0;
          step_cnt_d = '0;
        end
      end

      ST_SPIN: begin
        spin_cnt_d = spin_cnt_q + SPIN_CNT_W'(1);
        // Animate the wheel: sample the running LFSR every STEP_DIV cycles.
        if (step_cnt_q == STEP_LAST) begin
          display_d  = lfsr_q;
          step_cnt_d = '0;
        end else begin
          step_cnt_d = step_cnt_q + STEP_CNT_W'(1);
        end
        if (spin_cnt_q == SPIN_LAST) begin
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // Out-of-range values are skipped; the LFSR keeps advancing, and
        // every value 1..31 appears once per period, so this terminates.
        if (lfsr_in_range) begin
          result_d  = lfsr_q;
          odd_d     = lfsr_q[0];
          display_d = lfsr_q;
          state_d   = ST_DONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, counter and result registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      lfsr_q     <= SEED;
      spin_cnt_q <= '0;
      step_cnt_q <= '0;
      display_q  <= 5'd0;
      result_q   <= 5'd0;
      odd_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      spin_cnt_q <= spin_cnt_d;
      step_cnt_q <= step_cnt_d;
      display_q  <= display_d;
      result_q   <= result_d;
      odd_q      <= odd_d;
    end
  end

  assign busy         = (state_q == ST_SPIN) || (state_q == ST_SETTLE);
  assign result_valid = (state_q == ST_DONE);
  assign display      = display_q;
  assign result       = result_q;
  assign result_odd   = odd_q;

endmodule

// File: tb/tb_roulette_spinner.sv
// Directed bench for roulette_spinner: a RANGE_MAX=10 instance for the
// timing-exact scenarios and a RANGE_MAX=31 instance for result coverage.

module tb_roulette_spinner;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spin1_n, seed_load1;
  logic [4:0] seed1;
  logic       busy1, odd1, rv1;
  logic [4:0] display1, result1;
  logic       spin2_n, seed_load2;
  logic [4:0] seed2;
  logic       busy2, odd2, rv2;
  logic [4:0] display2, result2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  roulette_spinner #(
    .RANGE_MAX(10), .SPIN_CYCLES(8), .STEP_DIV(2), .SEED(5'b10101)
  ) u_dut1 (
    .clk(clk), .reset_n(reset_n), .spin_n(spin1_n), .seed_load(seed_load1),
    .seed(seed1), .busy(busy1), .display(display1), .result(result1),
    .result_odd(odd1), .result_valid(rv1)
  );

  roulette_spinner #(
    .RANGE_MAX(31), .SPIN_CYCLES(8), .STEP_DIV(2), .SEED(5'b10101)
  ) u_dut2 (
    .clk(clk), .reset_n(reset_n), .spin_n(spin2_n), .seed_load(seed_load2),
    .seed(seed2), .busy(busy2), .display(display2), .result(result2),
    .result_odd(odd2), .result_valid(rv2)
  );

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick();
    tick();
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy1); end
    n_checks++; if (result1 !== 5'd0) begin n_fail++; $display("FAIL reset_result: got %0d expected 0", result1); end
    n_checks++; if (rv1 !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", rv1); end
    n_checks++; if (display1 !== 5'd0) begin n_fail++; $display("FAIL reset_display: got %0d expected 0", display1); end
    n_checks++; if (odd1 !== 1'b0) begin n_fail++; $display("FAIL reset_odd: got %b expected 0", odd1); end
    n_checks++; if (u_dut1.lfsr_q !== 5'b10101) begin n_fail++; $display("FAIL reset_lfsr: got %0d expected 21", u_dut1.lfsr_q); end
    reset_n = 1'b1;
    tick();
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy: got %b expected 0", busy1); end
    $display("reset: busy=%b result=%0d valid=%b display=%0d", busy1, result1, rv1, display1);
  endtask

  task automatic test_seed_load();
    logic [4:0] exp_seq [5];
    exp_seq = '{5'd1, 5'd2, 5'd4, 5'd9, 5'd18};
    seed_load1 = 1'b1;
    seed1      = 5'd0;
    tick();
    seed_load1 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      if (k > 0) tick();
      n_checks++;
      if (u_dut1.lfsr_q !== exp_seq[k]) begin
        n_fail++; $display("FAIL seed0_lfsr step %0d: got %0d expected %0d", k, u_dut1.lfsr_q, exp_seq[k]);
      end
    end
    seed_load1 = 1'b1;
    seed1      = 5'd22;
    tick();
    seed_load1 = 1'b0;
    n_checks++; if (u_dut1.lfsr_q !== 5'd22) begin n_fail++; $display("FAIL seed22_load: got %0d expected 22", u_dut1.lfsr_q); end
    tick();
    n_checks++; if (u_dut1.lfsr_q !== 5'd12) begin n_fail++; $display("FAIL seed22_next: got %0d expected 12", u_dut1.lfsr_q); end
    $display("seed_load: seed 0 -> 1,2,4,9,18 and seed 22 -> 22,12 checked");
  endtask

  // Seed 0 loaded at edge L, key sampled low at L+1; the spin runs over
  // edges L+3..L+11, the display follows LFSR values 18,11,12,19 and the
  // settle step picks LFSR value 7 at L+12.
  task automatic test_single_spin();
    logic [4:0] exp_disp;
    logic       exp_busy, exp_rv;
    seed_load1 = 1'b1;
    seed1      = 5'd0;
    tick();
    seed_load1 = 1'b0;
    spin1_n    = 1'b0;
    tick();
    spin1_n    = 1'b1;
    for (int n = 2; n <= 30; n++) begin
      tick();
      exp_busy = (n >= 3) && (n <= 11);
      exp_rv   = (n == 12);
      if (n < 5)       exp_disp = 5'd0;
      else if (n < 7)  exp_disp = 5'd18;
      else if (n < 9)  exp_disp = 5'd11;
      else if (n < 11) exp_disp = 5'd12;
      else if (n < 12) exp_disp = 5'd19;
      else             exp_disp = 5'd7;
      n_checks++; if (busy1 !== exp_busy) begin n_fail++; $display("FAIL single_busy edge L+%0d: got %b expected %b", n, busy1, exp_busy); end
      n_checks++; if (rv1 !== exp_rv) begin n_fail++; $display("FAIL single_valid edge L+%0d: got %b expected %b", n, rv1, exp_rv); end
      n_checks++; if (display1 !== exp_disp) begin n_fail++; $display("FAIL single_display edge L+%0d: got %0d expected %0d", n, display1, exp_disp); end
      if (n >= 12) begin
        n_checks++; if (result1 !== 5'd7) begin n_fail++; $display("FAIL single_result edge L+%0d: got %0d expected 7", n, result1); end
        n_checks++; if (odd1 !== 1'b1) begin n_fail++; $display("FAIL single_odd edge L+%0d: got %b expected 1", n, odd1); end
      end
    end
    $display("single_spin: result=%0d odd=%b display=%0d", result1, odd1, display1);
  endtask

  task automatic test_back_to_back();
    int         pulses;
    logic [4:0] cap;
    // Second press lands while the first spin is still running.
    pulses = 0;
    cap    = 5'd0;
    spin1_n = 1'b0; tick(); spin1_n = 1'b1;
    repeat (5) tick();
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL b2b_busy_mid: got %b expected 1", busy1); end
    spin1_n = 1'b0; tick(); spin1_n = 1'b1;
    for (int n = 0; n < 60; n++) begin
      tick();
      if (rv1) begin
        pulses++;
        cap = result1;
        n_checks++; if (odd1 !== result1[0]) begin n_fail++; $display("FAIL b2b_odd: got %b expected %b", odd1, result1[0]); end
      end
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL b2b_pulses: got %0d expected 1", pulses); end
    n_checks++; if (cap < 5'd1 || cap > 5'd10) begin n_fail++; $display("FAIL b2b_range: got %0d expected 1..10", cap); end
    $display("back_to_back: pulses=%0d result=%0d", pulses, cap);
    // Key held low for 50 cycles is a single request.
    pulses  = 0;
    spin1_n = 1'b0;
    for (int n = 0; n < 50; n++) begin tick(); if (rv1) pulses++; end
    spin1_n = 1'b1;
    for (int n = 0; n < 20; n++) begin tick(); if (rv1) pulses++; end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL held_pulses: got %0d expected 1", pulses); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL held_busy_end: got %b expected 0", busy1); end
    $display("held_press: pulses=%0d", pulses);
  endtask

  task automatic test_reset_mid_spin();
    int pulses;
    pulses  = 0;
    reset_n = 1'b0; tick(); tick(); reset_n = 1'b1; tick();
    n_checks++; if (result1 !== 5'd0) begin n_fail++; $display("FAIL midrst_pre_result: got %0d expected 0", result1); end
    spin1_n = 1'b0; tick(); spin1_n = 1'b1;
    tick();
    tick();
    repeat (4) tick();
    n_checks++; if (busy1 !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b expected 1", busy1); end
    reset_n = 1'b0;
    tick();
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_in_reset: got %b expected 0", busy1); end
    reset_n = 1'b1;
    for (int n = 0; n < 40; n++) begin tick(); if (rv1) pulses++; end
    n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midrst_pulses: got %0d expected 0", pulses); end
    n_checks++; if (result1 !== 5'd0) begin n_fail++; $display("FAIL midrst_result: got %0d expected 0", result1); end
    n_checks++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL midrst_busy_after: got %b expected 0", busy1); end
    n_checks++; if (display1 !== 5'd0) begin n_fail++; $display("FAIL midrst_display: got %0d expected 0", display1); end
    $display("reset_mid_spin: pulses=%0d result=%0d", pulses, result1);
  endtask

  // 1000 spins on the full-range instance; varying idle gaps shift the
  // LFSR phase so every value 1..31 should turn up.
  task automatic test_coverage();
    logic seen [32];
    int   cnt, missing;
    logic got;
    for (int v = 0; v < 32; v++) seen[v] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      spin2_n = 1'b0; tick(); spin2_n = 1'b1;
      cnt = 0;
      got = 1'b0;
      while (!got && cnt < 50) begin
        tick();
        cnt++;
        if (rv2) got = 1'b1;
      end
      n_checks++;
      if (!got || cnt > 8 + 32 + 2) begin
        n_fail++; $display("FAIL cov_latency spin %0d: got %0d cycles expected <= 42", i, cnt);
      end else begin
        seen[result2] = 1'b1;
        n_checks++; if (result2 === 5'd0) begin n_fail++; $display("FAIL cov_zero spin %0d: got 0 expected 1..31", i); end
        n_checks++; if (odd2 !== result2[0]) begin n_fail++; $display("FAIL cov_odd spin %0d: got %b expected %b", i, odd2, result2[0]); end
        n_checks++; if (display2 !== result2) begin n_fail++; $display("FAIL cov_display spin %0d: got %0d expected %0d", i, display2, result2); end
      end
      repeat (1 + (i % 4)) tick();
    end
    missing = 0;
    for (int v = 1; v < 32; v++) if (!seen[v]) missing++;
    n_checks++; if (missing != 0) begin n_fail++; $display("FAIL cov_values: got %0d values missing expected 0", missing); end
    n_checks++; if (seen[0] !== 1'b0) begin n_fail++; $display("FAIL cov_zero_seen: got %b expected 0", seen[0]); end
    $display("coverage: 1000 spins, %0d of 31 values missing", missing);
  endtask

  initial begin
    reset_n    = 1'b0;
    spin1_n    = 1'b1;
    spin2_n    = 1'b1;
    seed_load1 = 1'b0;
    seed_load2 = 1'b0;
    seed1      = 5'd0;
    seed2      = 5'd0;
    #1;
    test_reset();
    test_seed_load();
    test_single_spin();
    test_back_to_back();
    test_reset_mid_spin();
    test_coverage();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
